// File: rtl/match_line_feeder.sv
// Assembles ACE CD snoop beats into a cache line, hands it to the pattern matcher,
// and publishes the matcher result with saturating full/partial match counters.
module match_line_feeder #(
    parameter int unsigned CL_SIZE    = 64,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [DATA_WIDTH-1:0]   i_cd_data,
    input  logic                    i_cd_valid,
    input  logic                    i_cd_last,
    output logic                    o_cd_ready,
    output logic [CL_SIZE*8-1:0]    o_cache_line,
    output logic                    o_trigger,
    input  logic                    i_full_match,
    input  logic                    i_partial_match,
    input  logic [3:0]              i_match_offset,
    input  logic                    i_op_end,
    output logic                    o_result_valid,
    output logic                    o_full_match,
    output logic                    o_partial_match,
    output logic [3:0]              o_match_offset,
    output logic                    o_err,
    input  logic                    i_clear_counts,
    output logic [15:0]             o_full_count,
    output logic [15:0]             o_partial_count
);

    localparam int unsigned LINE_W = CL_SIZE * 8;
    localparam int unsigned BEATS  = LINE_W / DATA_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned OFF_W  = 4;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WAIT    = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                trigger_q, trigger_d;
    logic                result_valid_q, result_valid_d;
    logic                full_q, full_d;
    logic                partial_q, partial_d;
    logic [OFF_W-1:0]    offset_q, offset_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    full_cnt_q, full_cnt_d;
    logic [CNT_W-1:0]    partial_cnt_q, partial_cnt_d;
    logic                capture;

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_COLLECT;
            beat_cnt_q     <= '0;
            wait_cnt_q     <= '0;
            line_q         <= '0;
            trigger_q      <= 1'b0;
            result_valid_q <= 1'b0;
            full_q         <= 1'b0;
            partial_q      <= 1'b0;
            offset_q       <= '0;
            err_q          <= 1'b0;
            full_cnt_q     <= '0;
            partial_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            wait_cnt_q     <= wait_cnt_d;
            line_q         <= line_d;
            trigger_q      <= trigger_d;
            result_valid_q <= result_valid_d;
            full_q         <= full_d;
            partial_q      <= partial_d;
            offset_q       <= offset_d;
            err_q          <= err_d;
            full_cnt_q     <= full_cnt_d;
            partial_cnt_q  <= partial_cnt_d;
        end
    end

    // Next-state, line assembly, result capture and counters
    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        wait_cnt_d     = wait_cnt_q;
        line_d         = line_q;
        trigger_d      = trigger_q;
        result_valid_d = 1'b0;
        full_d         = full_q;
        partial_d      = partial_q;
        offset_d       = offset_q;
        err_d          = 1'b0;
        full_cnt_d     = full_cnt_q;
        partial_cnt_d  = partial_cnt_q;
        capture        = 1'b0;

        case (state_q)
            S_COLLECT: begin
                trigger_d  = 1'b0;
                wait_cnt_d = '0;
                if (i_cd_valid) begin
                    line_d[32'(beat_cnt_q) * DATA_WIDTH +: DATA_WIDTH] = i_cd_data;
                    if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = S_WAIT;
                        trigger_d  = 1'b1;
                        err_d      = ~i_cd_last;
                    end else if (i_cd_last) begin
                        // Short line: drop it and restart at word 0
                        beat_cnt_d = '0;
                        err_d      = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (i_op_end) begin
                    capture        = 1'b1;
                    full_d         = i_full_match;
                    partial_d      = i_partial_match;
                    offset_d       = i_match_offset;
                    result_valid_d = 1'b1;
                    trigger_d      = 1'b0;
                    wait_cnt_d     = '0;
                    state_d        = S_REPORT;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    trigger_d  = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_REPORT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_REPORT: begin
                // One guaranteed low-trigger cycle lets the matcher reset
                trigger_d = 1'b0;
                state_d   = S_COLLECT;
            end
            default: begin
                trigger_d = 1'b0;
                state_d   = S_COLLECT;
            end
        endcase

        if (i_clear_counts) begin
            full_cnt_d    = '0;
            partial_cnt_d = '0;
        end else if (capture) begin
            if (i_full_match && (full_cnt_q != {CNT_W{1'b1}})) begin
                full_cnt_d = full_cnt_q + CNT_W'(1);
            end
            if (i_partial_match && (partial_cnt_q != {CNT_W{1'b1}})) begin
                partial_cnt_d = partial_cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_cd_ready      = (state_q == S_COLLECT);
    assign o_cache_line    = line_q;
    assign o_trigger       = trigger_q;
    assign o_result_valid  = result_valid_q;
    assign o_full_match    = full_q;
    assign o_partial_match = partial_q;
    assign o_match_offset  = offset_q;
    assign o_err           = err_q;
    assign o_full_count    = full_cnt_q;
    assign o_partial_count = partial_cnt_q;

endmodule

// File: tb/tb_match_line_feeder.sv
// Directed/randomized bench for match_line_feeder; the bench plays both the CD source
// and the combinational matcher, and predicts every output from the block's rules.
module tb_match_line_feeder;

    localparam int DW    = 128;
    localparam int LW    = 512;
    localparam int BEATS = LW / DW;
    localparam int TO    = 8;

    logic            i_clk;
    logic            i_rst;
    logic [DW-1:0]   i_cd_data;
    logic            i_cd_valid;
    logic            i_cd_last;
    logic            o_cd_ready;
    logic [LW-1:0]   o_cache_line;
    logic            o_trigger;
    logic            i_full_match;
    logic            i_partial_match;
    logic [3:0]      i_match_offset;
    logic            i_op_end;
    logic            o_result_valid;
    logic            o_full_match;
    logic            o_partial_match;
    logic [3:0]      o_match_offset;
    logic            o_err;
    logic            i_clear_counts;
    logic [15:0]     o_full_count;
    logic [15:0]     o_partial_count;

    int compared   = 0;
    int mismatched = 0;

    // Reference state: last published result and counter values
    logic       exp_full;
    logic       exp_part;
    logic [3:0] exp_off;
    int         exp_fc;
    int         exp_pc;

    match_line_feeder dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_cd_data       (i_cd_data),
        .i_cd_valid      (i_cd_valid),
        .i_cd_last       (i_cd_last),
        .o_cd_ready      (o_cd_ready),
        .o_cache_line    (o_cache_line),
        .o_trigger       (o_trigger),
        .i_full_match    (i_full_match),
        .i_partial_match (i_partial_match),
        .i_match_offset  (i_match_offset),
        .i_op_end        (i_op_end),
        .o_result_valid  (o_result_valid),
        .o_full_match    (o_full_match),
        .o_partial_match (o_partial_match),
        .o_match_offset  (o_match_offset),
        .o_err           (o_err),
        .i_clear_counts  (i_clear_counts),
        .o_full_count    (o_full_count),
        .o_partial_count (o_partial_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, LW'(obs), LW'(exp));
    endtask

    task automatic chk_results(input string tag);
        chk1({tag, "_full"}, o_full_match, exp_full);
        chk1({tag, "_part"}, o_partial_match, exp_part);
        chk({tag, "_off"}, LW'(o_match_offset), LW'(exp_off));
        chk({tag, "_fcnt"}, LW'(o_full_count), LW'(exp_fc));
        chk({tag, "_pcnt"}, LW'(o_partial_count), LW'(exp_pc));
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int sat_inc(input int c, input logic en);
        if (!en) return c;
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    // One full line; matcher answers op_at WAIT cycles in (op_at >= TO means never)
    task automatic do_line(input logic [LW-1:0] line, input logic last_ok, input int op_at,
                           input logic fm, input logic pm, input logic [3:0] off, input logic clr);
        bit got;
        got = 0;
        for (int k = 0; k < BEATS; k++) begin
            i_cd_valid = 1'b1;
            i_cd_data  = line[k*DW +: DW];
            i_cd_last  = (k == BEATS - 1) ? last_ok : 1'b0;
            chk1("collect_ready", o_cd_ready, 1'b1);
            tick();
        end
        i_cd_valid = 1'b0;
        i_cd_last  = 1'b0;
        chk1("trig_rise", o_trigger, 1'b1);
        chk("line", o_cache_line, line);
        chk1("last_err", o_err, ~last_ok);
        chk1("wait_ready", o_cd_ready, 1'b0);
        i_full_match    = fm;
        i_partial_match = pm;
        i_match_offset  = off;
        for (int w = 0; w < TO; w++) begin
            i_op_end       = (w == op_at);
            i_clear_counts = clr && (w == op_at);
            tick();
            if (w == op_at) begin
                got = 1;
                break;
            end
            if (w == TO - 1) break;
            chk1("wait_trig", o_trigger, 1'b1);
            chk1("wait_rv", o_result_valid, 1'b0);
            chk1("wait_err", o_err, 1'b0);
        end
        i_op_end       = 1'b0;
        i_clear_counts = 1'b0;
        if (got) begin
            exp_full = fm;
            exp_part = pm;
            exp_off  = off;
            exp_fc   = clr ? 0 : sat_inc(exp_fc, fm);
            exp_pc   = clr ? 0 : sat_inc(exp_pc, pm);
            chk1("result_rv", o_result_valid, 1'b1);
            chk1("result_err", o_err, 1'b0);
        end else begin
            chk1("timeout_rv", o_result_valid, 1'b0);
            chk1("timeout_err", o_err, 1'b1);
        end
        chk_results("report");
        chk1("report_trig", o_trigger, 1'b0);
        chk1("report_ready", o_cd_ready, 1'b0);
        tick();
        chk1("resume_ready", o_cd_ready, 1'b1);
        chk1("resume_rv", o_result_valid, 1'b0);
        chk1("resume_err", o_err, 1'b0);
    endtask

    task automatic early_last(input int k_last);
        for (int k = 0; k <= k_last; k++) begin
            i_cd_valid = 1'b1;
            i_cd_data  = {$urandom, $urandom, $urandom, $urandom};
            i_cd_last  = (k == k_last);
            tick();
        end
        i_cd_valid = 1'b0;
        i_cd_last  = 1'b0;
        chk1("early_err", o_err, 1'b1);
        chk1("early_trig", o_trigger, 1'b0);
        chk1("early_ready", o_cd_ready, 1'b1);
        tick();
        chk1("early_err_pulse", o_err, 1'b0);
        chk1("early_trig2", o_trigger, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_line"}, o_cache_line, '0);
        chk1({tag, "_trig"}, o_trigger, 1'b0);
        chk1({tag, "_rv"}, o_result_valid, 1'b0);
        chk1({tag, "_err"}, o_err, 1'b0);
        chk_results(tag);
        chk1({tag, "_ready"}, o_cd_ready, 1'b1);
    endtask

    initial begin : stim
        logic [LW-1:0] line;
        logic [LW-1:0] lines [3];
        int            pulse_cyc [3];
        int            np;
        int            li;
        int            bi;
        bit            acc;

        i_rst = 1'b1; i_cd_data = '0; i_cd_valid = 1'b0; i_cd_last = 1'b0;
        i_full_match = 1'b0; i_partial_match = 1'b0; i_match_offset = '0;
        i_op_end = 1'b0; i_clear_counts = 1'b0;
        exp_full = 1'b0; exp_part = 1'b0; exp_off = '0; exp_fc = 0; exp_pc = 0;

        tick();
        tick();
        chk_reset_state("reset");
        i_rst = 1'b0;
        tick();
        chk1("post_reset_ready", o_cd_ready, 1'b1);

        // Aligned full match
        line = rnd_line();
        line[0*DW +: DW] = DW'(32'hA);
        line[1*DW +: DW] = DW'(32'hB);
        line[2*DW +: DW] = DW'(32'hC);
        do_line(line, 1'b1, 0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Partial match at offset 13
        do_line(rnd_line(), 1'b1, int'($urandom_range(0, 3)), 1'b0, 1'b1, 4'd13, 1'b0);

        // Random results with random matcher latency
        for (int n = 0; n < 4; n++) begin
            do_line(rnd_line(), 1'b1, int'($urandom_range(0, TO - 2)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 1'b0);
        end

        // Early last, then a fresh aligned line; then a full line missing its last flag
        early_last(1);
        do_line(rnd_line(), 1'b1, 0, 1'b1, 1'b1, 4'd3, 1'b0);
        do_line(rnd_line(), 1'b0, 2, 1'b0, 1'b1, 4'd9, 1'b0);

        // Timeout: matcher never finishes
        do_line(rnd_line(), 1'b1, TO, 1'b1, 1'b1, 4'd15, 1'b0);

        // Back-to-back lines with valid held high and an immediate matcher
        for (int n = 0; n < 3; n++) lines[n] = rnd_line();
        for (int n = 0; n < 3; n++) pulse_cyc[n] = 0;
        np = 0; li = 0; bi = 0;
        i_op_end = 1'b1; i_full_match = 1'b1; i_partial_match = 1'b0; i_match_offset = 4'd5;
        for (int cyc = 0; cyc < 60 && np < 3; cyc++) begin
            if (li < 3) begin
                i_cd_valid = 1'b1;
                i_cd_data  = lines[li][bi*DW +: DW];
                i_cd_last  = (bi == BEATS - 1);
            end else begin
                i_cd_valid = 1'b0;
                i_cd_last  = 1'b0;
            end
            acc = i_cd_valid && o_cd_ready;
            tick();
            if (acc) begin
                bi++;
                if (bi == BEATS) begin
                    bi = 0;
                    chk("b2b_line", o_cache_line, lines[li]);
                    chk1("b2b_trig", o_trigger, 1'b1);
                    li++;
                end
            end
            if (o_result_valid) begin
                pulse_cyc[np] = cyc;
                np++;
                chk1("b2b_trig_low", o_trigger, 1'b0);
            end
        end
        i_op_end = 1'b0; i_cd_valid = 1'b0; i_cd_last = 1'b0;
        chk("b2b_pulses", LW'(np), LW'(3));
        chk("b2b_gap01", LW'(pulse_cyc[1] - pulse_cyc[0]), LW'(6));
        chk("b2b_gap12", LW'(pulse_cyc[2] - pulse_cyc[1]), LW'(6));
        exp_full = 1'b1; exp_part = 1'b0; exp_off = 4'd5;
        for (int n = 0; n < 3; n++) exp_fc = sat_inc(exp_fc, 1'b1);
        tick();
        chk1("b2b_ready", o_cd_ready, 1'b1);
        chk_results("b2b");

        // Reset mid-line drops the partial line and clears everything
        for (int k = 0; k < 2; k++) begin
            i_cd_valid = 1'b1;
            i_cd_data  = {$urandom, $urandom, $urandom, $urandom};
            i_cd_last  = 1'b0;
            tick();
        end
        i_cd_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_full = 1'b0; exp_part = 1'b0; exp_off = '0; exp_fc = 0; exp_pc = 0;
        chk_reset_state("midreset");
        tick();
        chk1("midreset_ready", o_cd_ready, 1'b1);
        do_line(rnd_line(), 1'b1, 1, 1'b0, 1'b1, 4'd6, 1'b0);

        // Counter saturation and clear priority
        force dut.full_cnt_q = 16'hFFFF;
        force dut.partial_cnt_q = 16'hFFFF;
        tick();
        release dut.full_cnt_q;
        release dut.partial_cnt_q;
        tick();
        exp_fc = 65535; exp_pc = 65535;
        chk("preload_fcnt", LW'(o_full_count), LW'(exp_fc));
        chk("preload_pcnt", LW'(o_partial_count), LW'(exp_pc));
        do_line(rnd_line(), 1'b1, 0, 1'b1, 1'b1, 4'd7, 1'b0);
        do_line(rnd_line(), 1'b1, 1, 1'b1, 1'b1, 4'd2, 1'b1);
        do_line(rnd_line(), 1'b1, 0, 1'b1, 1'b0, 4'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/match_line_feeder.md
# match_line_feeder

Upstream stage of the pattern matcher. Accepts snoop-data beats from the ACE CD channel and assembles them into one full cache line. Drives the matcher's line and trigger inputs, captures the matcher's result, and publishes it as a one-cycle result pulse. Also keeps saturating full- and partial-match counters for the register file.

## Interface
Parameters:
- CL_SIZE, 64: cache-line size in bytes. Line width is CL_SIZE*8.
- DATA_WIDTH, 128: CD beat width in bits. BEATS = CL_SIZE*8/DATA_WIDTH, which is 4 at the defaults.
- TIMEOUT, 8: maximum WAIT cycles allowed without i_op_end.

Ports (one clock; reset is synchronous and active-high):
- i_clk, in, 1: clock.
- i_rst, in, 1: synchronous active-high reset.
- i_cd_data, in, DATA_WIDTH: snoop data beat.
- i_cd_valid, in, 1: beat valid.
- i_cd_last, in, 1: last beat of the line.
- o_cd_ready, out, 1: beat accepted when valid and ready are both high.
- o_cache_line, out, CL_SIZE*8: assembled line, to the matcher.
- o_trigger, out, 1: matcher trigger, level-held.
- i_full_match, in, 1: matcher result.
- i_partial_match, in, 1: matcher result.
- i_match_offset, in, 4: matcher result.
- i_op_end, in, 1: matcher result valid.
- o_result_valid, out, 1: one-cycle result pulse.
- o_full_match, out, 1: registered result, held until the next result.
- o_partial_match, out, 1: registered result, held until the next result.
- o_match_offset, out, 4: registered result, held until the next result.
- o_err, out, 1: one-cycle pulse on protocol error or timeout.
- i_clear_counts, in, 1: zeroes both counters.
- o_full_count, out, 16: saturating count of full matches.
- o_partial_count, out, 16: saturating count of partial matches.

## Operation
- FSM states are COLLECT, WAIT and REPORT. Reset state is COLLECT.
- COLLECT:
  - o_cd_ready=1 and o_trigger=0.
  - Accepted beat k (k = beat_cnt) is written to o_cache_line[k*DATA_WIDTH +: DATA_WIDTH]. Beat 0 occupies the LSBs, i.e. word 0.
  - beat_cnt increments on each accepted beat.
- Line completion and protocol errors in COLLECT:
  - Beat BEATS-1 accepted: beat_cnt←0, state→WAIT, o_trigger←1.
  - Beat BEATS-1 accepted with i_cd_last=0: the line is still processed, and o_err pulses.
  - i_cd_last=1 on a beat k<BEATS-1: the line is discarded, beat_cnt←0, o_err pulses, and state stays COLLECT. No trigger is issued.
- WAIT:
  - o_cd_ready=0, o_trigger=1, and o_cache_line is stable.
  - On a cycle with i_op_end=1: capture i_full_match, i_partial_match and i_match_offset into the output registers. Then o_result_valid←1, o_trigger←0, state→REPORT.
  - If wait_cnt reaches TIMEOUT-1 without i_op_end: o_err←1, o_trigger←0, results stay unchanged, no o_result_valid, state→REPORT.
- REPORT:
  - o_cd_ready=0 and o_trigger=0. This guarantees at least one low trigger cycle between lines, which resets the matcher.
  - Next state is COLLECT.
- Counters:
  - On a captured result, o_full_count increments when i_full_match=1 and o_partial_count increments when i_partial_match=1.
  - Both counters saturate at 16'hFFFF.
  - i_clear_counts zeroes both counters and takes priority over a same-cycle increment.
- Reset (i_rst=1 at an edge), including mid-line and mid-WAIT:
  - All outputs become 0 and o_cache_line becomes 0.
  - beat_cnt, wait_cnt and both counters become 0.
  - State→COLLECT. Any partial line is dropped.
  - o_cd_ready reads 1 in the first cycle after reset is released.

## Timing
- All outputs are registered except o_cd_ready, which is decoded from state (COLLECT only).
- Final beat accepted at edge N:
  - o_trigger is high after edge N.
  - The matcher is combinational, so i_op_end is sampled at edge N+1.
  - o_result_valid is high between edges N+1 and N+2.
  - o_cd_ready is high again after edge N+2.
- Sustained throughput is one line per BEATS+2 cycles, i.e. 6 cycles at the defaults.
- Valid-to-ready has no combinational path. i_cd_valid may rise in any state; a beat is held by the source until accepted.
- o_err and o_result_valid are each exactly one cycle wide. They are never both high in the same cycle.

## Test plan
- Aligned full match:
  - Stimulus: 4 beats with words 0..2 = 0xA,0xB,0xC; matcher model returns full=1, offset=0; last on beat 3.
  - Required: o_trigger rises after beat 3; o_result_valid pulses at N+1; o_full_match=1; o_full_count=1; o_cd_ready returns at N+2.
- Partial match:
  - Stimulus: model returns partial=1, offset=13.
  - Required: o_partial_match=1; o_match_offset=13; o_partial_count=1; o_full_match=0.
- Early last:
  - Stimulus: i_cd_last on beat 1.
  - Required: o_err pulses once; no trigger; the next 4 beats form a fresh line with beat 0 at the LSBs.
- Timeout:
  - Stimulus: model never asserts i_op_end.
  - Required: o_err pulses after 8 WAIT cycles; no o_result_valid; o_trigger drops; COLLECT is resumed.
- Back-to-back lines with valid held high:
  - Stimulus: 3 consecutive lines with i_cd_valid continuously high.
  - Required: exactly 3 result pulses, 6 cycles apart; o_trigger low for at least 1 cycle between lines.
- Reset mid-line and counter saturation:
  - Stimulus: i_rst after 2 beats; then preload counts to 16'hFFFF and inject one more full match; then assert i_clear_counts in the same cycle as an increment.
  - Required: after reset, all outputs are 0 and the partial line is discarded; o_full_count stays 16'hFFFF; i_clear_counts wins, giving a count of 0.
